// File: rtl/run_controller_pkg.sv
// run_controller_pkg
//   Shared types and constants for the run/halt/step/breakpoint sequencer.
//   run_state_t    : 2-bit sequencer state (HALT/RUN/STEP/BREAK)
//   STATE_WIDTH    : width of the state field seen by the debug monitor
//   STATE_*        : raw state encodings used by the debug monitor
//   DEBOUNCE_CYCLES_DEFAULT : default button stability window in cycles
package run_controller_pkg;

  localparam int STATE_WIDTH = 2;

  typedef enum logic [STATE_WIDTH-1:0] {
    HALT  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    BREAK = 2'd3
  } run_state_t;

  localparam logic [STATE_WIDTH-1:0] STATE_HALT  = 2'd0;
  localparam logic [STATE_WIDTH-1:0] STATE_RUN   = 2'd1;
  localparam logic [STATE_WIDTH-1:0] STATE_STEP  = 2'd2;
  localparam logic [STATE_WIDTH-1:0] STATE_BREAK = 2'd3;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/run_controller_if.sv
// run_controller_if
//   Bundles the board buttons, the CPU-side breakpoint/decoder inputs and the
//   sequencer outputs into one interface.
//   master : board + CPU side (drives buttons, pc, haltRequest, breakpoint)
//   slave  : run_controller (drives cpuEnable, state, breakHit, cycleCount)
interface run_controller_if
  import run_controller_pkg::*;
#(
  parameter int PC_WIDTH          = 8,
  parameter int CYCLE_COUNT_WIDTH = 16
);

  logic                         runButton;
  logic                         stepButton;
  logic                         haltButton;
  logic                         breakEnable;
  logic [PC_WIDTH-1:0]          breakAddress;
  logic [PC_WIDTH-1:0]          pc;
  logic                         haltRequest;
  logic                         cpuEnable;
  logic [STATE_WIDTH-1:0]       state;
  logic                         breakHit;
  logic [CYCLE_COUNT_WIDTH-1:0] cycleCount;

  modport master (
    output runButton, stepButton, haltButton,
    output breakEnable, breakAddress, pc, haltRequest,
    input  cpuEnable, state, breakHit, cycleCount
  );

  modport slave (
    input  runButton, stepButton, haltButton,
    input  breakEnable, breakAddress, pc, haltRequest,
    output cpuEnable, state, breakHit, cycleCount
  );

endinterface

// File: rtl/run_controller_button_debounce.sv
// button_debounce
//   Turns a raw asynchronous pushbutton into a clean one-cycle press pulse.
//   clock      : system clock, rising edge
//   isResetN   : asynchronous active-low reset
//   rawButton  : raw pushbutton level, high = pressed
//   pulse      : one-cycle pulse on each accepted press (never on release)
module button_debounce
  import run_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic isResetN,
  input  logic rawButton,
  output logic pulse
);

  localparam int COUNT_WIDTH = $clog2(DEBOUNCE_CYCLES);
  localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                   syncStage1;
  logic                   syncStage2;
  logic                   acceptedLevel;
  logic                   levelDelayed;
  logic [COUNT_WIDTH-1:0] stableCount;

  // Two-flop synchronizer feeds a stability counter. The counter restarts
  // whenever the synchronized input agrees with the accepted level, so the
  // level only flips after DEBOUNCE_CYCLES back-to-back disagreeing samples.
  // The pulse is taken from the accepted level against its one-cycle-old
  // copy, so only a rising accepted level produces a pulse.
  always_ff @(posedge clock or negedge isResetN) begin
    if (!isResetN) begin
      syncStage1    <= 1'b0;
      syncStage2    <= 1'b0;
      acceptedLevel <= 1'b0;
      levelDelayed  <= 1'b0;
      stableCount   <= '0;
      pulse         <= 1'b0;
    end else begin
      syncStage1 <= rawButton;
      syncStage2 <= syncStage1;
      if (syncStage2 == acceptedLevel) begin
        stableCount <= '0;
      end else if (stableCount == COUNT_LAST) begin
        acceptedLevel <= syncStage2;
        stableCount   <= '0;
      end else begin
        stableCount <= stableCount + COUNT_WIDTH'(1);
      end
      levelDelayed <= acceptedLevel;
      pulse        <= acceptedLevel & ~levelDelayed;
    end
  end

endmodule

// File: rtl/run_controller.sv
// run_controller
//   Run/halt/single-step/breakpoint sequencer producing the CPU clock enable.
//   clock     : system clock, rising edge
//   isResetN  : asynchronous active-low reset
//   bus       : run_controller_if.slave
//     inputs  : runButton, stepButton, haltButton, breakEnable,
//               breakAddress, pc, haltRequest
//     outputs : cpuEnable (combinational), state, breakHit (sticky),
//               cycleCount (enabled cycles, wrapping)
module run_controller
  import run_controller_pkg::*;
#(
  parameter int PC_WIDTH          = 8,
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CYCLE_COUNT_WIDTH = 16
) (
  input  logic           clock,
  input  logic           isResetN,
  run_controller_if.slave bus
);

  run_state_t                   currentState;
  logic                         resumeFlag;
  logic                         breakHitFlag;
  logic [CYCLE_COUNT_WIDTH-1:0] cycleCounter;
  logic                         runPulse;
  logic                         stepPulse;
  logic                         haltPulse;
  logic                         breakMatch;
  logic                         cpuEnableComb;
  logic [PC_WIDTH-1:0]          pcValue;
  logic [PC_WIDTH-1:0]          breakAddressValue;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) runDebounce (
    .clock    (clock),
    .isResetN (isResetN),
    .rawButton(bus.runButton),
    .pulse    (runPulse)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) stepDebounce (
    .clock    (clock),
    .isResetN (isResetN),
    .rawButton(bus.stepButton),
    .pulse    (stepPulse)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) haltDebounce (
    .clock    (clock),
    .isResetN (isResetN),
    .rawButton(bus.haltButton),
    .pulse    (haltPulse)
  );

  assign pcValue           = bus.pc;
  assign breakAddressValue = bus.breakAddress;

  // The resume flag masks the match for the first RUN cycle after BREAK so
  // the instruction sitting at the breakpoint can finally execute.
  assign breakMatch = bus.breakEnable && (pcValue == breakAddressValue) && !resumeFlag;

  // The enable reacts in the same cycle to stop causes seen while running,
  // so a halt instruction or breakpoint instruction never executes.
  always_comb begin
    cpuEnableComb = 1'b0;
    case (currentState)
      RUN:     cpuEnableComb = !(haltPulse || bus.haltRequest || breakMatch);
      STEP:    cpuEnableComb = 1'b1;
      default: cpuEnableComb = 1'b0;
    endcase
  end

  // Sequencer state, resume flag, sticky breakpoint flag and the enabled-cycle
  // counter. Coincident pulses resolve halt over step over run. STEP always
  // falls back to HALT after its single enabled cycle, whatever else happens.
  always_ff @(posedge clock or negedge isResetN) begin
    if (!isResetN) begin
      currentState <= HALT;
      resumeFlag   <= 1'b0;
      breakHitFlag <= 1'b0;
      cycleCounter <= '0;
    end else begin
      if (cpuEnableComb) begin
        cycleCounter <= cycleCounter + CYCLE_COUNT_WIDTH'(1);
      end
      case (currentState)
        HALT: begin
          if (haltPulse) begin
            currentState <= HALT;
          end else if (stepPulse) begin
            currentState <= STEP;
          end else if (runPulse) begin
            currentState <= RUN;
          end
        end
        RUN: begin
          resumeFlag <= 1'b0;
          if (haltPulse || bus.haltRequest) begin
            currentState <= HALT;
          end else if (breakMatch) begin
            currentState <= BREAK;
            breakHitFlag <= 1'b1;
          end
        end
        STEP: begin
          currentState <= HALT;
        end
        BREAK: begin
          if (haltPulse) begin
            currentState <= HALT;
          end else if (stepPulse) begin
            currentState <= STEP;
            breakHitFlag <= 1'b0;
          end else if (runPulse) begin
            currentState <= RUN;
            resumeFlag   <= 1'b1;
            breakHitFlag <= 1'b0;
          end
        end
        default: begin
          currentState <= HALT;
        end
      endcase
    end
  end

  assign bus.cpuEnable  = cpuEnableComb;
  assign bus.state      = currentState;
  assign bus.breakHit   = breakHitFlag;
  assign bus.cycleCount = cycleCounter;

endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller
//   Bench for run_controller with DEBOUNCE_CYCLES=4 and a 4-bit cycle counter.
//   A table of button vectors, hand-written multi-cycle sequences and a
//   randomized phase run against a behavioural model that checks every cycle.
module tb_run_controller;

  localparam int PCW = 8;
  localparam int D   = 4;
  localparam int CCW = 4;

  localparam int S_HALT  = 0;
  localparam int S_RUN   = 1;
  localparam int S_STEP  = 2;
  localparam int S_BREAK = 3;

  logic clock    = 1'b0;
  logic isResetN = 1'b0;

  int testsRun    = 0;
  int testsFailed = 0;

  run_controller_if #(.PC_WIDTH(PCW), .CYCLE_COUNT_WIDTH(CCW)) bus ();

  run_controller #(
    .PC_WIDTH         (PCW),
    .DEBOUNCE_CYCLES  (D),
    .CYCLE_COUNT_WIDTH(CCW)
  ) dut (
    .clock   (clock),
    .isResetN(isResetN),
    .bus     (bus)
  );

  // Free-running 10 ns clock.
  always #5 clock = ~clock;

  // Hard stop in case something never finishes.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time exceeded, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, required %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: a button press is accepted once the last D samples
  // seen behind the two-stage synchronizer all disagree with the accepted
  // level; a pulse appears one cycle after the level rises.
  logic [D+1:0] hist [3] = '{default: '0};
  bit mLevel [3] = '{default: 1'b0};
  bit mRose  [3] = '{default: 1'b0};
  bit mPulse [3] = '{default: 1'b0};
  int mState    = S_HALT;
  int mCount    = 0;
  bit mResume   = 1'b0;
  bit mBreakHit = 1'b0;

  function automatic bit rawOf(input int b);
    case (b)
      0:       return bus.runButton;
      1:       return bus.stepButton;
      default: return bus.haltButton;
    endcase
  endfunction

  function automatic bit modelBreakMatch();
    return bus.breakEnable && (bus.pc == bus.breakAddress) && !mResume;
  endfunction

  function automatic bit expEnable();
    if (mState == S_STEP) return 1'b1;
    if (mState != S_RUN) return 1'b0;
    return !(mPulse[2] || bus.haltRequest || modelBreakMatch());
  endfunction

  initial begin
    forever begin : modelStep
      bit en;
      bit pr;
      bit ps;
      bit ph;
      bit match;
      @(posedge clock or negedge isResetN);
      if (!isResetN) begin
        for (int b = 0; b < 3; b++) begin
          hist[b]   = '0;
          mLevel[b] = 1'b0;
          mRose[b]  = 1'b0;
          mPulse[b] = 1'b0;
        end
        mState    = S_HALT;
        mCount    = 0;
        mResume   = 1'b0;
        mBreakHit = 1'b0;
      end else begin
        en    = expEnable();
        match = modelBreakMatch();
        pr    = mPulse[0];
        ps    = mPulse[1];
        ph    = mPulse[2];
        mCount = (mCount + int'(en)) % (1 << CCW);
        if (mState == S_HALT) begin
          mState = ph ? S_HALT : (ps ? S_STEP : (pr ? S_RUN : S_HALT));
        end else if (mState == S_RUN) begin
          mResume = 1'b0;
          if (ph || bus.haltRequest) begin
            mState = S_HALT;
          end else if (match) begin
            mState    = S_BREAK;
            mBreakHit = 1'b1;
          end
        end else if (mState == S_STEP) begin
          mState = S_HALT;
        end else begin
          if (ph) begin
            mState = S_HALT;
          end else if (ps) begin
            mState    = S_STEP;
            mBreakHit = 1'b0;
          end else if (pr) begin
            mState    = S_RUN;
            mResume   = 1'b1;
            mBreakHit = 1'b0;
          end
        end
        for (int b = 0; b < 3; b++) begin
          bit allDiffer;
          hist[b]   = {hist[b][D:0], rawOf(b)};
          mPulse[b] = mRose[b];
          mRose[b]  = 1'b0;
          allDiffer = 1'b1;
          for (int k = 2; k <= D + 1; k++) begin
            if (hist[b][k] == mLevel[b]) allDiffer = 1'b0;
          end
          if (allDiffer) begin
            mLevel[b] = !mLevel[b];
            mRose[b]  = mLevel[b];
          end
        end
      end
    end
  end

  // Scoreboard: compare every output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clock);
      checkOutput("sb.state", int'(bus.state), mState);
      checkOutput("sb.cpuEnable", int'(bus.cpuEnable), int'(expEnable()));
      checkOutput("sb.breakHit", int'(bus.breakHit), int'(mBreakHit));
      checkOutput("sb.cycleCount", int'(bus.cycleCount), mCount);
    end
  end

  typedef struct {
    bit [2:0] buttons;
    bit       haltReq;
    int       expState;
    bit       expEnable;
  } vector_t;

  vector_t vectors [9];

  task automatic setButtons(input bit [2:0] mask);
    bus.runButton  = mask[0];
    bus.stepButton = mask[1];
    bus.haltButton = mask[2];
  endtask

  // One clock with a CPU that advances pc whenever it was enabled.
  task automatic cpuCycle();
    bit en;
    #1;
    en = bus.cpuEnable;
    @(posedge clock);
    #2;
    if (en) bus.pc = bus.pc + 8'd1;
  endtask

  task automatic cpuCycles(input int n);
    for (int i = 0; i < n; i++) cpuCycle();
  endtask

  task automatic applyStimulus(input vector_t v, input int idx);
    bus.haltRequest = v.haltReq;
    setButtons(v.buttons);
    cpuCycles(D + 4);
    #1;
    checkOutput($sformatf("vec%0d.state", idx), int'(bus.state), v.expState);
    checkOutput($sformatf("vec%0d.cpuEnable", idx), int'(bus.cpuEnable), int'(v.expEnable));
    setButtons(3'b000);
    cpuCycles(D + 8);
  endtask

  initial begin
    logic [PCW-1:0] pcBefore;
    int enCount;

    vectors[0] = '{3'b101, 1'b0, S_HALT, 1'b0};
    vectors[1] = '{3'b011, 1'b0, S_STEP, 1'b1};
    vectors[2] = '{3'b001, 1'b0, S_RUN,  1'b1};
    vectors[3] = '{3'b010, 1'b0, S_RUN,  1'b1};
    vectors[4] = '{3'b101, 1'b0, S_HALT, 1'b0};
    vectors[5] = '{3'b010, 1'b1, S_STEP, 1'b1};
    vectors[6] = '{3'b001, 1'b1, S_RUN,  1'b0};
    vectors[7] = '{3'b001, 1'b0, S_RUN,  1'b1};
    vectors[8] = '{3'b100, 1'b0, S_HALT, 1'b0};

    setButtons(3'b000);
    bus.haltRequest  = 1'b0;
    bus.breakEnable  = 1'b0;
    bus.breakAddress = '0;
    bus.pc           = '0;

    // Reset values, then run held from the first edge after release.
    repeat (2) @(posedge clock);
    #2;
    checkOutput("reset.state", int'(bus.state), S_HALT);
    checkOutput("reset.cpuEnable", int'(bus.cpuEnable), 0);
    checkOutput("reset.cycleCount", int'(bus.cycleCount), 0);
    checkOutput("reset.breakHit", int'(bus.breakHit), 0);
    bus.runButton = 1'b1;
    isResetN      = 1'b1;
    cpuCycles(D + 3);
    checkOutput("debounce.edge7.state", int'(bus.state), S_HALT);
    cpuCycles(1);
    checkOutput("debounce.edge8.state", int'(bus.state), S_RUN);
    checkOutput("debounce.edge8.cpuEnable", int'(bus.cpuEnable), 1);
    setButtons(3'b000);
    cpuCycles(D + 8);

    // A 3-cycle halt glitch while running must be filtered out.
    bus.haltButton = 1'b1;
    cpuCycles(3);
    bus.haltButton = 1'b0;
    cpuCycles(D + 8);
    checkOutput("glitch.halt.state", int'(bus.state), S_RUN);
    bus.haltButton = 1'b1;
    cpuCycles(D + 4);
    checkOutput("halt.press.state", int'(bus.state), S_HALT);
    setButtons(3'b000);
    cpuCycles(D + 8);
    bus.stepButton = 1'b1;
    cpuCycles(3);
    bus.stepButton = 1'b0;
    cpuCycles(D + 8);
    checkOutput("glitch.step.state", int'(bus.state), S_HALT);

    // Table of button combinations applied from known states.
    for (int i = 0; i < 9; i++) applyStimulus(vectors[i], i);
    bus.haltRequest = 1'b0;

    // Halt instruction at pc 0x12 stops the CPU in the same cycle.
    bus.pc = 8'h10;
    bus.runButton = 1'b1;
    cpuCycles(D + 4);
    setButtons(3'b000);
    for (int i = 0; i < 64 && bus.pc != 8'h12; i++) cpuCycle();
    checkOutput("haltInstr.reachPc", int'(bus.pc), 8'h12);
    bus.haltRequest = 1'b1;
    #1;
    checkOutput("haltInstr.cpuEnable", int'(bus.cpuEnable), 0);
    cpuCycle();
    checkOutput("haltInstr.state", int'(bus.state), S_HALT);
    cpuCycles(3);
    checkOutput("haltInstr.pcHeld", int'(bus.pc), 8'h12);
    bus.haltRequest = 1'b0;
    cpuCycles(D + 8);

    // Breakpoint at 0x05, then resume past it.
    bus.pc           = 8'h00;
    bus.breakAddress = 8'h05;
    bus.breakEnable  = 1'b1;
    bus.runButton    = 1'b1;
    cpuCycles(D + 4);
    setButtons(3'b000);
    for (int i = 0; i < 40 && bus.state != 2'(S_BREAK); i++) cpuCycle();
    #1;
    checkOutput("break.state", int'(bus.state), S_BREAK);
    checkOutput("break.pc", int'(bus.pc), 8'h05);
    checkOutput("break.breakHit", int'(bus.breakHit), 1);
    checkOutput("break.cpuEnable", int'(bus.cpuEnable), 0);
    cpuCycles(D + 8);
    checkOutput("break.held", int'(bus.state), S_BREAK);
    bus.runButton = 1'b1;
    cpuCycles(D + 4);
    #1;
    checkOutput("resume.state", int'(bus.state), S_RUN);
    checkOutput("resume.cpuEnable", int'(bus.cpuEnable), 1);
    checkOutput("resume.breakHit", int'(bus.breakHit), 0);
    cpuCycle();
    checkOutput("resume.pc", int'(bus.pc), 8'h06);
    checkOutput("resume.stillRun", int'(bus.state), S_RUN);
    setButtons(3'b100);
    cpuCycles(D + 4);
    checkOutput("resume.halted", int'(bus.state), S_HALT);
    setButtons(3'b000);
    bus.breakEnable = 1'b0;
    cpuCycles(D + 8);

    // Single step advances the CPU by exactly one instruction.
    pcBefore = bus.pc;
    bus.stepButton = 1'b1;
    cpuCycles(D + 4);
    #1;
    checkOutput("step.state", int'(bus.state), S_STEP);
    checkOutput("step.cpuEnable", int'(bus.cpuEnable), 1);
    setButtons(3'b000);
    cpuCycles(D + 8);
    checkOutput("step.back", int'(bus.state), S_HALT);
    checkOutput("step.pc", int'(bus.pc), int'(pcBefore + 8'd1));

    // Counter wrap after 17 enabled cycles, then asynchronous reset mid-RUN.
    isResetN = 1'b0;
    cpuCycles(2);
    bus.runButton = 1'b1;
    isResetN      = 1'b1;
    enCount       = 0;
    for (int i = 0; i < 60 && enCount < 17; i++) begin
      if (bus.cpuEnable) enCount++;
      cpuCycle();
    end
    checkOutput("wrap.enabledCycles", enCount, 17);
    checkOutput("wrap.cycleCount", int'(bus.cycleCount), 1);
    #1;
    isResetN = 1'b0;
    #1;
    checkOutput("asyncReset.state", int'(bus.state), S_HALT);
    checkOutput("asyncReset.cycleCount", int'(bus.cycleCount), 0);
    checkOutput("asyncReset.cpuEnable", int'(bus.cpuEnable), 0);
    @(posedge clock);
    @(posedge clock);
    #2;
    isResetN = 1'b1;
    cpuCycles(D + 3);
    checkOutput("release.edge7.state", int'(bus.state), S_HALT);
    cpuCycles(1);
    checkOutput("release.edge8.state", int'(bus.state), S_RUN);
    setButtons(3'b100);
    cpuCycles(D + 4);
    setButtons(3'b000);
    cpuCycles(D + 8);

    // Randomized phase, checked cycle by cycle against the model.
    begin
      int burstLeft [3];
      for (int b = 0; b < 3; b++) burstLeft[b] = 0;
      bus.breakEnable  = 1'b1;
      bus.breakAddress = 8'h03;
      for (int i = 0; i < 1500; i++) begin
        for (int b = 0; b < 3; b++) begin
          if (burstLeft[b] > 0) burstLeft[b]--;
          else if ($urandom_range(0, 30) == 0) burstLeft[b] = $urandom_range(1, 14);
        end
        setButtons({burstLeft[2] > 0, burstLeft[1] > 0, burstLeft[0] > 0});
        bus.haltRequest = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 99) == 0) bus.breakEnable = ~bus.breakEnable;
        bus.pc   = 8'($urandom_range(0, 7));
        isResetN = ($urandom_range(0, 399) != 0);
        @(posedge clock);
        #2;
      end
    end

    isResetN = 1'b1;
    setButtons(3'b000);
    bus.haltRequest = 1'b0;
    repeat (4) @(posedge clock);
    #2;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/run_controller.md
# run_controller

Run/halt/single-step/breakpoint sequencer for the 8-bit CPU core. It sits between the board pushbuttons and the CPU, and produces the `cpuEnable` clock-enable that gates PC update and register-file writes. It debounces three buttons and stops execution on a halt instruction or a PC breakpoint. It also counts executed cycles for the debug monitor.

## Interface
Parameters:
- `PC_WIDTH`, 8, width of `pc` and `breakAddress`
- `DEBOUNCE_CYCLES`, 16, consecutive stable cycles required before a button level is accepted (≥2)
- `CYCLE_COUNT_WIDTH`, 16, width of `cycleCount`

Ports:
- `clock`  input  1  single system clock, rising edge
- `isResetN`  input  1  reset, asynchronous assert, active-low
- `runButton`  input  1  raw asynchronous pushbutton, high = pressed
- `stepButton`  input  1  raw asynchronous pushbutton
- `haltButton`  input  1  raw asynchronous pushbutton
- `breakEnable`  input  1  breakpoint switch, treated as quasi-static
- `breakAddress`  input  PC_WIDTH  breakpoint PC
- `pc`  input  PC_WIDTH  current CPU program counter
- `haltRequest`  input  1  decoder flag: the instruction at `pc` is a halt
- `cpuEnable`  output  1  CPU clock enable (combinational from state and inputs)
- `state`  output  2  current state encoding
- `breakHit`  output  1  sticky breakpoint flag
- `cycleCount`  output  CYCLE_COUNT_WIDTH  number of cycles with `cpuEnable`=1

## Operation
- **Reset values:** `state`=HALT, `breakHit`=0, `cycleCount`=0, resume flag=0, all debouncers report level 0 with no pulse. `cpuEnable`=0 throughout reset.
- **Button path:**
  - Two-flop synchronizer, then a stability counter.
  - The accepted level changes only after DEBOUNCE_CYCLES consecutive cycles of differing input.
  - A rising edge of the accepted level gives a one-cycle pulse.
  - Release bounce produces no pulse.
- **Pulse priority when coincident:** halt > step > run.
- **States:** HALT=0, RUN=1, STEP=2, BREAK=3.
- **HALT:** `cpuEnable`=0.
  - stepPulse → STEP.
  - runPulse → RUN.
- **RUN:** `cpuEnable`=1 unless stopped. Priority of stop causes:
  1. haltPulse → HALT, `cpuEnable`=0 that cycle.
  2. haltRequest → HALT, `cpuEnable`=0; the halt instruction is not executed.
  3. breakEnable & pc==breakAddress & !resume → BREAK, `cpuEnable`=0, `breakHit` set; the instruction at breakAddress is not executed.
- **STEP:** `cpuEnable`=1 for exactly one cycle, then → HALT unconditionally.
  - STEP ignores breakpoint and haltRequest, so stepping past a halt or breakpoint is possible.
  - A haltPulse in STEP is ignored; the state goes to HALT anyway.
- **BREAK:** `cpuEnable`=0.
  - runPulse → RUN with resume=1.
  - stepPulse → STEP.
  - haltPulse → HALT.
  - runPulse and stepPulse both clear `breakHit`.
- **Resume flag:** suppresses breakpoint matching for exactly the first RUN cycle after leaving BREAK, then clears. This prevents an immediate re-break at the same PC.
- **Cycle counter:** `cycleCount` increments on every clock with `cpuEnable`=1 and wraps from all-ones to 0.
- **breakEnable toggled while in BREAK:** no effect until the next RUN.

## Timing
- Button latency: the pulse is asserted exactly DEBOUNCE_CYCLES+3 rising edges after a raw button rises and stays high. The pulse is 1 cycle wide.
- A button held indefinitely produces exactly one pulse.
- State register update: 1 cycle after the qualifying pulse or condition.
  - `cpuEnable` responds combinationally to haltRequest and breakpoint match in RUN (same cycle).
  - `cpuEnable` responds to button pulses with a one-cycle registered latency.
- Reset mid-operation: immediate asynchronous return to reset values. A pulse in flight is discarded.
- Release: the first pulse is possible only after DEBOUNCE_CYCLES+3 cycles of a pressed button following reset deassertion.

## Structure
- Package `run_controller_pkg` holds:
  - `run_state_t` enum (HALT/RUN/STEP/BREAK, 2-bit)
  - `DEBOUNCE_CYCLES` default
  - the state encodings used by the debug monitor
- Sub-module `button_debounce` (synchronizer + stability counter + edge pulse) is parameterized by DEBOUNCE_CYCLES and instantiated three times.
- `run_controller` contains the FSM, resume flag, `breakHit` and `cycleCount`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- **Reset/debounce:** hold runButton high from cycle 0 → runPulse at edge 7 only; `state`=RUN from edge 8. A 3-cycle glitch on stepButton → no pulse.
- **Halt instruction:** RUN, raise haltRequest at pc=0x12 → `cpuEnable`=0 in the same cycle, `state`=HALT next edge, `cycleCount` frozen.
- **Breakpoint:** breakEnable=1, breakAddress=0x05, PC counting from 0 → `cpuEnable` low at pc=0x05, `state`=BREAK, `breakHit`=1. Then press run → pc advances to 0x06 without re-break and `breakHit`=0.
- **Single step:** in HALT, press step → exactly one `cpuEnable` cycle, `cycleCount`+1, back to HALT. Stepping with haltRequest=1 also advances.
- **Simultaneous pulses:** run and halt buttons pressed on the same cycle while in HALT → `state` remains HALT. Step+run together → STEP.
- **Wrap and async reset:** CYCLE_COUNT_WIDTH=4, run for 17 enabled cycles → `cycleCount`=1. Assert isResetN low mid-RUN → `state`=HALT and `cycleCount`=0 asynchronously.
